sweep_controller: RTL
=====================

# sweep_controller

Frequency-sweep sequencer that drives the 32-bit phase-increment (`adder`) input of the signal generator in the 200 MHz `maxClk` domain. It latches a sweep configuration, steps `adder` from a start value to a stop value in fixed increments, and holds each value for a programmable dwell time. Every new value is applied only on a phase-accumulator wrap, so the output waveform never glitches mid-period. It sits between the UART parameter registers and `signalGenerator`.

## Interface

Parameters:
- `W`, 32, width of adder/step values
- `DWELL_W`, 24, width of dwell counter (clk cycles)

Ports:
- `clk`  in  1  generator clock (200 MHz)
- `resetN`  in  1  synchronous, active-low reset
- `cfg_valid`  in  1  one-cycle strobe; latch cfg_* when `cfg_ready`=1
- `cfg_start`  in  W  first adder value
- `cfg_stop`  in  W  last adder value
- `cfg_step`  in  W  increment per step
- `cfg_dwell`  in  DWELL_W  clk cycles per point; 0 is treated as 1
- `cfg_mode`  in  2  00 single up, 01 repeat up, 10 triangle, 11 hold start
- `start`  in  1  one-cycle strobe; begin sweep with latched config
- `abort`  in  1  one-cycle strobe; stop sweep
- `phase_wrap`  in  1  one-cycle tick from generator on accumulator overflow
- `adder`  out  W  phase increment to generator
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at end of single sweep
- `cfg_ready`  out  1  config may be written (high when not busy)
- `cfg_err`  out  1  one-cycle pulse; config rejected

## Operation

- Reset (`resetN`=0 at a clk edge):
  - state IDLE
  - `adder`=0, `busy`=0, `done`=0, `cfg_err`=0, `cfg_ready`=1
  - latched config cleared to 0
- Config latch:
  - `cfg_valid` with `cfg_ready`=1 latches all cfg_* fields.
  - If `cfg_start` > `cfg_stop` (unsigned), nothing is latched and `cfg_err` pulses.
  - `cfg_valid` while busy is ignored, with no error pulse.
- States:
  - IDLE: `start` → ARM.
  - ARM: wait for `phase_wrap`, then `adder`←start, load dwell → DWELL.
  - DWELL: count down; at terminal count → STEP_WAIT, next value precomputed.
  - STEP_WAIT: wait for `phase_wrap`, then `adder`←next, reload dwell → DWELL. If the point just finished was the last one: single mode → DONE; repeat → ARM.
  - DONE: `done` pulses for one cycle → IDLE.
- Next-value arithmetic uses W+1 bits:
  - Up: sum = adder + step. If sum > stop or overflows, next = stop. The point at stop is the last point of the leg.
  - Triangle: direction flips at stop and at start. Down: diff = adder − step; if diff < start or underflows, next = start.
  - Triangle never terminates; only `abort` ends it.
- Mode 11 (hold): load start on the first wrap, then stay in DWELL indefinitely with no stepping. Exits only on `abort`.
- `step`=0 or start==stop: a single point. Single mode → DONE after one dwell; repeat → reapply the same value at each dwell.
- `abort`: from any non-IDLE state, → IDLE on the next edge. `adder` holds its current value; no `done` pulse. `abort` and `start` in the same cycle: abort wins and the controller stays IDLE.
- `start` while busy is ignored.
- `busy`=1 in ARM, DWELL and STEP_WAIT.

## Timing

- `adder` changes on the clk edge after the cycle where `phase_wrap`=1 is sampled (1-cycle latency), and only in ARM or STEP_WAIT.
- Each point holds for at least `cfg_dwell` cycles plus the wait for the next wrap.
- `busy` rises the cycle after `start`. It falls together with the `done` pulse (in the DONE cycle) or the cycle after `abort`.
- `cfg_ready` = ~`busy`, registered.
- `cfg_err` asserts the cycle after the rejected `cfg_valid`.
- No combinational path from any input to any output.

## Structure

- Package `awg_pkg` holds:
  - state enum `sweep_state_t` (IDLE, ARM, DWELL, STEP_WAIT, DONE)
  - mode constants `MODE_SINGLE`, `MODE_REPEAT`, `MODE_TRI`, `MODE_HOLD`
- Sub-module `dwell_counter`: loadable down-counter with `load`, `value`, `tc` terminal-count output; it treats 0 as 1.
- Next-value adder/comparator stays in `sweep_controller`.

## Test plan

- Reset, then config start=100, stop=400, step=100, dwell=10, mode 00, with `phase_wrap` every 16 cycles → `adder` steps through 100, 200, 300, 400, each change 1 cycle after a wrap; then one `done` pulse and `busy`=0.
- start=0, stop=250, step=100, mode 00 → sequence 0, 100, 200, 250 (clamped); then `done`.
- Mode 10, start=10, stop=30, step=10 → 10, 20, 30, 20, 10, 20, … with no `done`; `abort` mid-dwell → `busy`=0 next cycle and `adder` holds its value.
- cfg start=500, stop=100 → `cfg_err` pulse; previous config is retained, and a subsequent sweep uses it.
- `start` and `abort` in the same cycle → remains IDLE; `cfg_valid` while busy → ignored; start=stop=0xFFFFFFF0 with step=0x20 → no overflow, single point, `done`.
- Assert `resetN`=0 during DWELL → all outputs return to reset values at the next edge; `cfg_dwell`=0 → one-cycle dwell.

Source files
------------

// File: rtl/awg_pkg.sv
// Shared types and constants for the arbitrary-waveform generator sweep logic.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package awg_pkg;

   // Sweep sequencer states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      DWELL     = 3'd2,
      STEP_WAIT = 3'd3,
      DONE      = 3'd4
   } sweep_state_t;

   // Sweep modes as carried on cfg_mode
   localparam logic [1:0] MODE_SINGLE = 2'b00;
   localparam logic [1:0] MODE_REPEAT = 2'b01;
   localparam logic [1:0] MODE_TRI    = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter timing how long each sweep point is held; a load of 0 counts as 1.
// Latency: tc is high in the value-th enabled cycle after load (decode of the count register).
// Backpressure: none; count only advances while en is high and stops at 1.
module dwell_counter #(
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               load,
   input  logic               en,
   input  logic [DWELL_W-1:0] value,
   output logic               tc
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   // Next count: load has priority; otherwise decrement while enabled, parking at 1
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = (value == '0) ? DWELL_W'(1) : value;
      end else if (en && (cnt_q > DWELL_W'(1))) begin
         cnt_d = cnt_q - DWELL_W'(1);
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetN) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/sweep_controller.sv
// Frequency-sweep sequencer stepping the generator phase increment on accumulator wraps.
// Latency: adder updates 1 cycle after a sampled phase_wrap; all outputs are registered.
// Backpressure: cfg_ready is low while busy and cfg_valid is dropped silently then.
module sweep_controller
   import awg_pkg::*;
#(
   parameter int W       = 32,
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               cfg_valid,
   input  logic [W-1:0]       cfg_start,
   input  logic [W-1:0]       cfg_stop,
   input  logic [W-1:0]       cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic               start,
   input  logic               abort,
   input  logic               phase_wrap,
   output logic [W-1:0]       adder,
   output logic               busy,
   output logic               done,
   output logic               cfg_ready,
   output logic               cfg_err
);

   sweep_state_t state_q, state_d;

   logic [W-1:0]       adder_q, adder_d;
   logic [W-1:0]       next_q, next_d;
   logic               last_q, last_d;
   logic               dir_q, dir_d;      // triangle direction, 1 = stepping down
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cfg_ready_q, cfg_ready_d;
   logic               cfg_err_q, cfg_err_d;
   logic [W-1:0]       sw_start_q, sw_start_d;
   logic [W-1:0]       sw_stop_q, sw_stop_d;
   logic [W-1:0]       sw_step_q, sw_step_d;
   logic [DWELL_W-1:0] sw_dwell_q, sw_dwell_d;
   logic [1:0]         sw_mode_q, sw_mode_d;

   logic               dwell_load, dwell_en, dwell_tc;
   logic [W:0]         sum_w, diff_w;
   logic [W-1:0]       up_val, down_val, nxt_val;
   logic               nxt_last, nxt_dir;

   dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
      .clk    (clk),
      .resetN (resetN),
      .load   (dwell_load),
      .en     (dwell_en),
      .value  (sw_dwell_q),
      .tc     (dwell_tc)
   );

   // Next sweep point from the current one, with one spare bit to catch wrap-around
   always_comb begin
      sum_w    = {1'b0, adder_q} + {1'b0, sw_step_q};
      diff_w   = {1'b0, adder_q} - {1'b0, sw_step_q};
      up_val   = (sum_w > {1'b0, sw_stop_q}) ? sw_stop_q : sum_w[W-1:0];
      down_val = (diff_w[W] || (diff_w[W-1:0] < sw_start_q)) ? sw_start_q : diff_w[W-1:0];
      nxt_val  = up_val;
      nxt_dir  = dir_q;
      nxt_last = (adder_q >= sw_stop_q) || (sw_step_q == '0);
      if (sw_mode_q == MODE_TRI) begin
         nxt_last = 1'b0;
         if (!dir_q) begin
            if (adder_q >= sw_stop_q) begin
               nxt_val = down_val;
               nxt_dir = 1'b1;
            end
         end else begin
            if (adder_q <= sw_start_q) begin
               nxt_dir = 1'b0;
            end else begin
               nxt_val = down_val;
            end
         end
      end
   end

   // Sequencer next-state, config latch and registered output values
   always_comb begin
      state_d     = state_q;
      adder_d     = adder_q;
      next_d      = next_q;
      last_d      = last_q;
      dir_d       = dir_q;
      cfg_err_d   = 1'b0;
      sw_start_d  = sw_start_q;
      sw_stop_d   = sw_stop_q;
      sw_step_d   = sw_step_q;
      sw_dwell_d  = sw_dwell_q;
      sw_mode_d   = sw_mode_q;
      dwell_load  = 1'b0;
      dwell_en    = (state_q == DWELL);

      if (cfg_valid && cfg_ready_q) begin
         if (cfg_start > cfg_stop) begin
            cfg_err_d = 1'b1;
         end else begin
            sw_start_d = cfg_start;
            sw_stop_d  = cfg_stop;
            sw_step_d  = cfg_step;
            sw_dwell_d = cfg_dwell;
            sw_mode_d  = cfg_mode;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ARM;
               dir_d   = 1'b0;
            end
         end
         ARM: begin
            if (phase_wrap) begin
               adder_d    = sw_start_q;
               dwell_load = 1'b1;
               state_d    = DWELL;
            end
         end
         DWELL: begin
            // Hold mode parks here until abort
            if ((sw_mode_q != MODE_HOLD) && dwell_tc) begin
               next_d  = nxt_val;
               last_d  = nxt_last;
               dir_d   = nxt_dir;
               state_d = STEP_WAIT;
            end
         end
         STEP_WAIT: begin
            if (last_q) begin
               state_d = (sw_mode_q == MODE_SINGLE) ? DONE : ARM;
            end else if (phase_wrap) begin
               adder_d    = next_q;
               dwell_load = 1'b1;
               state_d    = DWELL;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort beats everything, including a simultaneous start or wrap
      if (abort) begin
         state_d    = IDLE;
         adder_d    = adder_q;
         dwell_load = 1'b0;
      end

      busy_d      = (state_d == ARM) || (state_d == DWELL) || (state_d == STEP_WAIT);
      done_d      = (state_d == DONE);
      cfg_ready_d = ~busy_d;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Datapath, latched configuration and output registers
   always_ff @(posedge clk) begin
      if (!resetN) begin
         adder_q     <= '0;
         next_q      <= '0;
         last_q      <= 1'b0;
         dir_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
         cfg_err_q   <= 1'b0;
         sw_start_q  <= '0;
         sw_stop_q   <= '0;
         sw_step_q   <= '0;
         sw_dwell_q  <= '0;
         sw_mode_q   <= '0;
      end else begin
         adder_q     <= adder_d;
         next_q      <= next_d;
         last_q      <= last_d;
         dir_q       <= dir_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
         sw_start_q  <= sw_start_d;
         sw_stop_q   <= sw_stop_d;
         sw_step_q   <= sw_step_d;
         sw_dwell_q  <= sw_dwell_d;
         sw_mode_q   <= sw_mode_d;
      end
   end

   assign adder     = adder_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;

endmodule
